me_frame_server: RTL and testbench

- Memory-side counterpart of the motion estimator core.
- Loads a 16x16 reference block and a 31x31 search window from a byte stream into internal storage.
- Pulses `start` to the estimator, then answers the estimator's AddressR/AddressS1/AddressS2 read requests on R/s1/s2.
- After a fixed run time, captures motionx/motiony and holds them for the host until acknowledged.

---
 rtl/me_frame_server.sv | 182 ++++++++++++++++++
 tb/tb_me_frame_server.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_server.sv
`default_nettype none
// ============================================================================
//  Module      : me_frame_server
//  Description : Memory-side partner of the motion estimator. Streams a
//                16x16 reference block and a 31x31 search window into local
//                storage, kicks the estimator with a one-cycle start pulse,
//                serves its three read ports combinationally, then captures
//                the motion vector after a fixed run time and holds it for
//                the host until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_frame_server #(
    parameter int R_SIZE         = 256,
    parameter int S_SIZE         = 961,
    parameter int RESULT_LATENCY = 4112,
    parameter int DATA_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    // host byte stream
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    // estimator interface
    output logic              start,
    input  logic [7:0]        AddressR,
    input  logic [9:0]        AddressS1,
    input  logic [9:0]        AddressS2,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] s1,
    output logic [DATA_W-1:0] s2,
    input  logic [3:0]        motionx,
    input  logic [3:0]        motiony,
    // host result interface
    output logic              result_valid,
    output logic [3:0]        result_x,
    output logic [3:0]        result_y,
    input  logic              result_ack,
    output logic              busy
);

    // The load counter spans the larger of the two arrays (0..960).
    localparam int c_cnt_w = 10;
    // The run counter must reach RESULT_LATENCY-2.
    localparam int c_run_w = $clog2(RESULT_LATENCY);

    localparam logic [c_cnt_w-1:0] c_r_last   = c_cnt_w'(R_SIZE - 1);
    localparam logic [c_cnt_w-1:0] c_s_last   = c_cnt_w'(S_SIZE - 1);
    localparam logic [9:0]         c_s_size   = 10'(S_SIZE);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(RESULT_LATENCY - 2);

    typedef enum logic [2:0] {
        ST_LOAD_R = 3'd0,
        ST_LOAD_S = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_run_w-1:0]  r_run_cnt;
    logic                r_load_ready;
    logic                r_start;
    logic                r_busy;
    logic                r_result_valid;
    logic [3:0]          r_result_x;
    logic [3:0]          r_result_y;

    logic [DATA_W-1:0]   r_mem [0:R_SIZE-1];
    logic [DATA_W-1:0]   s_mem [0:S_SIZE-1];

    logic                w_accept;
    logic                w_wr_r;
    logic                w_wr_s;

    // load_ready is only high in the two load states, so it qualifies the
    // transfer on its own; reset suppresses any write on its edge.
    assign w_accept = load_valid && r_load_ready;
    assign w_wr_r   = w_accept && (r_state == ST_LOAD_R) && !reset;
    assign w_wr_s   = w_accept && (r_state == ST_LOAD_S) && !reset;

    // Control FSM; all host/estimator handshake outputs are registered
    // alongside the state so they always agree with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_LOAD_R;
            r_cnt          <= '0;
            r_run_cnt      <= '0;
            r_load_ready   <= 1'b1;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_x     <= '0;
            r_result_y     <= '0;
        end else begin
            case (r_state)
                ST_LOAD_R: begin
                    if (w_accept) begin
                        if (r_cnt == c_r_last) begin
                            r_state <= ST_LOAD_S;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_S: begin
                    if (w_accept) begin
                        if (r_cnt == c_s_last) begin
                            r_state      <= ST_START;
                            r_cnt        <= '0;
                            r_load_ready <= 1'b0;
                            r_start      <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_state   <= ST_RUN;
                    r_start   <= 1'b0;
                    r_run_cnt <= '0;
                end
                ST_RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    // Last RUN edge: capture lands RESULT_LATENCY cycles
                    // after the start cycle.
                    if (r_run_cnt == c_run_last) begin
                        r_state        <= ST_DONE;
                        r_result_x     <= motionx;
                        r_result_y     <= motiony;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        r_state        <= ST_LOAD_R;
                        r_cnt          <= '0;
                        r_result_valid <= 1'b0;
                        r_load_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_LOAD_R;
                    r_cnt          <= '0;
                    r_run_cnt      <= '0;
                    r_load_ready   <= 1'b1;
                    r_start        <= 1'b0;
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    // Storage writes; arrays carry no reset so they map onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_wr_r) begin
            r_mem[r_cnt[7:0]] <= load_data;
        end
        if (w_wr_s) begin
            s_mem[r_cnt] <= load_data;
        end
    end

    // Zero-latency read ports; search-window addresses past the end read 0.
    assign R  = r_mem[AddressR];
    assign s1 = (AddressS1 < c_s_size) ? s_mem[AddressS1] : '0;
    assign s2 = (AddressS2 < c_s_size) ? s_mem[AddressS2] : '0;

    assign load_ready   = r_load_ready;
    assign start        = r_start;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result_x     = r_result_x;
    assign result_y     = r_result_y;

endmodule
`default_nettype wire

// File: tb/tb_me_frame_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_frame_server
//  Description : Self-checking bench for me_frame_server. Keeps a shadow copy
//                of both arrays and the expected result timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_frame_server;

    localparam int c_r_size  = 256;
    localparam int c_s_size  = 961;
    localparam int c_latency = 4112;
    localparam int c_total   = c_r_size + c_s_size;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       start;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [3:0] motionx;
    logic [3:0] motiony;
    logic       result_valid;
    logic [3:0] result_x;
    logic [3:0] result_y;
    logic       result_ack;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_r [c_r_size];
    logic [7:0] m_s [c_s_size];

    me_frame_server dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .start        (start),
        .AddressR     (AddressR),
        .AddressS1    (AddressS1),
        .AddressS2    (AddressS2),
        .R            (R),
        .s1           (s1),
        .s2           (s2),
        .motionx      (motionx),
        .motiony      (motiony),
        .result_valid (result_valid),
        .result_x     (result_x),
        .result_y     (result_y),
        .result_ack   (result_ack),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Stream up to n bytes in raster order (R block, then S window).
    // mode 0: R[i]=i, S[j]=3j; mode 1: random bytes. Idle cycles carry junk.
    task automatic load(input int mode, input bit throttle, input bit ack_noise, input int n);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit hs_bad = 0;
        logic [7:0] d;
        while (idx < n && cyc < 4000) begin
            v = !throttle || (cyc % 2 == 0);
            if (!v)
                d = 8'($urandom);
            else if (mode == 0)
                d = (idx < c_r_size) ? 8'(idx) : 8'((idx - c_r_size) * 3);
            else
                d = 8'($urandom);
            load_valid = v;
            load_data  = d;
            if (ack_noise) result_ack = 1'($urandom);
            if (load_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0)
                hs_bad = 1;
            tick;
            cyc++;
            if (v) begin
                if (idx < c_r_size) m_r[idx] = d;
                else                m_s[idx - c_r_size] = d;
                idx++;
            end
        end
        load_valid = 1'b0;
        result_ack = 1'b0;
        chk("load handshake outputs", 32'(hs_bad), 32'd0);
        chk("load accept count", idx, n);
    endtask

    // Read every location on all three ports and compare with the shadow copy.
    task automatic sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < c_r_size; i++) begin
            AddressR = 8'(i);
            #1;
            if (R !== m_r[i]) bad++;
        end
        for (int j = 0; j < c_s_size; j++) begin
            AddressS1 = 10'(j);
            AddressS2 = 10'(c_s_size - 1 - j);
            #1;
            if (s1 !== m_s[j]) bad++;
            if (s2 !== m_s[c_s_size - 1 - j]) bad++;
        end
        for (int k = c_s_size; k < 1024; k++) begin
            AddressS1 = 10'(k);
            AddressS2 = 10'(k);
            #1;
            if (s1 !== 8'd0 || s2 !== 8'd0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Called in the start cycle: run to capture, hold, then acknowledge.
    task automatic run_and_capture(input logic [3:0] mx, input logic [3:0] my);
        int n = 0;
        bit busy_bad = 0;
        bit hold_bad = 0;
        motionx = mx;
        motiony = my;
        while (result_valid !== 1'b1 && n < 5000) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            tick;
            n++;
            if (n == 1) chk("start is one cycle", 32'(start), 32'd0);
            if (result_valid !== 1'b1 && (busy !== 1'b1 || load_ready !== 1'b0)) busy_bad = 1;
        end
        chk("busy during run", 32'(busy_bad), 32'd0);
        chk("capture latency", n, c_latency);
        chk("result_x", 32'(result_x), 32'(mx));
        chk("result_y", 32'(result_y), 32'(my));
        chk("busy low in done", 32'(busy), 32'd0);
        chk("load_ready low in done", 32'(load_ready), 32'd0);
        motionx = ~mx;
        motiony = ~my;
        repeat (10) begin
            tick;
            if (result_valid !== 1'b1 || result_x !== mx || result_y !== my) hold_bad = 1;
        end
        chk("result held without ack", 32'(hold_bad), 32'd0);
        sweep("arrays untouched by run/done writes");
        load_valid = 1'b0;
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
        chk("result_valid cleared by ack", 32'(result_valid), 32'd0);
        chk("load_ready after ack", 32'(load_ready), 32'd1);
        chk("result_x kept after ack", 32'(result_x), 32'(mx));
    endtask

    initial begin
        logic [3:0] mx;
        logic [3:0] my;
        bit bad;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        AddressR   = '0;
        AddressS1  = '0;
        AddressS2  = '0;
        motionx    = '0;
        motiony    = '0;
        result_ack = 1'b0;

        // Reset values
        repeat (2) tick;
        chk("reset load_ready", 32'(load_ready), 32'd1);
        chk("reset start", 32'(start), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset result_x", 32'(result_x), 32'd0);
        chk("reset result_y", 32'(result_y), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Ack in LOAD_R has no effect
        result_ack = 1'b1;
        repeat (3) tick;
        result_ack = 1'b0;
        chk("ack in load_r ignored", {30'd0, result_valid, load_ready}, 32'd1);

        // Full load with the directed pattern
        load(0, 1'b0, 1'b0, c_total);
        chk("start after last accept", 32'(start), 32'd1);
        chk("busy in start", 32'(busy), 32'd1);
        chk("load_ready low in start", 32'(load_ready), 32'd0);
        AddressR = 8'h5A;
        #1 chk("R[0x5A]", 32'(R), 32'h5A);
        AddressS1 = 10'd100;
        #1 chk("s1[100]", 32'(s1), 32'h2C);
        AddressS2 = 10'd961;
        #1 chk("s2[961] out of range", 32'(s2), 32'd0);
        run_and_capture(4'h7, 4'h3);

        // Throttled load with random data and ack noise
        load(1, 1'b1, 1'b1, c_total);
        chk("start after throttled load", 32'(start), 32'd1);
        AddressR  = 8'd255;
        AddressS1 = 10'd960;
        #1;
        chk("R[255] throttled", 32'(R), 32'(m_r[255]));
        chk("s1[960] throttled", 32'(s1), 32'(m_s[960]));
        mx = 4'($urandom);
        my = 4'($urandom);
        run_and_capture(mx, my);

        // Reset in the middle of a load, then a fresh complete load
        load(1, 1'b0, 1'b0, 500);
        load_valid = 1'b1;
        reset      = 1'b1;
        tick;
        reset      = 1'b0;
        load_valid = 1'b0;
        chk("mid-load reset load_ready", 32'(load_ready), 32'd1);
        chk("mid-load reset busy", 32'(busy), 32'd0);
        chk("mid-load reset result_x", 32'(result_x), 32'd0);
        load(1, 1'b0, 1'b0, c_total);
        chk("start after reload", 32'(start), 32'd1);
        sweep("arrays after reload");

        // Reset during RUN: no capture afterwards
        motionx = 4'hA;
        motiony = 4'h5;
        repeat (2000) tick;
        chk("busy before run reset", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("run reset busy", 32'(busy), 32'd0);
        chk("run reset result_valid", 32'(result_valid), 32'd0);
        bad = 0;
        repeat (3000) begin
            tick;
            if (result_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || result_x !== 4'd0) bad = 1;
        end
        chk("no capture after run reset", 32'(bad), 32'd0);
        sweep("arrays survive reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
